adc_spi_capture: RTL

- Drives an external MCP3202-class 2-channel 12-bit SPI ADC.
- Produces a stereo pair of 16-bit signed PCM samples at a fixed sample rate.
- Sits upstream of the audio path; its samples feed the HDMI audio sample words.
- Runs entirely in the 27 MHz pixel clock domain and owns the adc_clk, adc_cs, adc_mosi and adc_miso pins.

---
 rtl/adc_spi_capture.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_capture.sv
`timescale 1ns/1ps
// Stereo capture from an MCP3202-class SPI ADC; one pair per sample tick, 74*CLK_DIV+2 clks per pair.
// No backpressure: sample_valid is a 1-clk pulse; ticks arriving while busy are dropped and flag overrun.
module adc_spi_capture #(
  parameter int CLK_DIV    = 8,
  parameter int SAMPLE_DIV = 612
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        adc_clk,
  output logic        adc_cs,
  output logic        adc_mosi,
  input  logic        adc_miso,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] HALF_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HI_START   = CW'(CLK_DIV);
  localparam logic [CW-1:0] CAP_CNT    = CW'(CLK_DIV + 1);
  localparam logic [CW-1:0] PER_END    = CW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_END   = TW'(SAMPLE_DIV - 1);
  localparam logic [4:0]    LAST_BIT   = 5'd16;
  localparam logic [4:0]    FIRST_DATA = 5'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_NEXT,
    S_DONE
  } state_t;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [1:0]    r_miso_sync;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [4:0]    r_bit, w_bit_nx;
  logic          r_ch, w_ch_nx;

  logic          w_cs_nx, w_sclk_nx, w_mosi_nx;
  logic          w_capture, w_hold_ch0, w_publish;
  logic          r_adc_cs, r_adc_clk, r_adc_mosi;
  logic [11:0]   r_shift, r_data0;
  logic [15:0]   r_left, r_right;
  logic          r_valid, r_overrun;

  function automatic logic cmd_bit(input logic [4:0] bit_idx, input logic ch);
    case (bit_idx)
      5'd0, 5'd1, 5'd3: cmd_bit = 1'b1;
      5'd2:             cmd_bit = ch;
      default:          cmd_bit = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] to_pcm(input logic [11:0] d);
    to_pcm = {~d[11], d[10:0], 4'b0000};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_tick = (r_tick_cnt == TICK_END);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_miso_sync <= 2'b00;
    else          r_miso_sync <= {r_miso_sync[0], adc_miso};
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_ch_nx    = r_ch;
    case (r_state)
      S_IDLE: begin
        if (w_tick && enable) begin
          w_state_nx = S_CS_SETUP;
          w_cnt_nx   = '0;
          w_ch_nx    = 1'b0;
        end
      end
      S_CS_SETUP: begin
        if (r_cnt == HALF_END) begin
          w_state_nx = S_SHIFT;
          w_cnt_nx   = '0;
          w_bit_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_SHIFT: begin
        if (r_cnt == PER_END) begin
          w_cnt_nx = '0;
          if (r_bit == LAST_BIT) w_state_nx = S_CS_HOLD;
          else                   w_bit_nx   = r_bit + 5'd1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_CS_HOLD: begin
        if (r_cnt == PER_END) begin
          w_cnt_nx   = '0;
          w_state_nx = r_ch ? S_DONE : S_NEXT;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_NEXT: begin
        w_ch_nx    = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = S_CS_SETUP;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase

    // Pin levels are decoded from the next state and registered so the SPI pins never glitch.
    w_cs_nx   = !((w_state_nx == S_CS_SETUP) || (w_state_nx == S_SHIFT));
    w_sclk_nx = (w_state_nx == S_SHIFT) && (w_cnt_nx >= HI_START);
    w_mosi_nx = (w_state_nx == S_CS_SETUP) ||
                ((w_state_nx == S_SHIFT) && cmd_bit(w_bit_nx, w_ch_nx));

    w_capture  = (r_state == S_SHIFT) && (r_cnt == CAP_CNT) && (r_bit >= FIRST_DATA);
    w_hold_ch0 = (r_state == S_CS_HOLD) && (r_cnt == PER_END) && !r_ch;
    w_publish  = (r_state == S_CS_HOLD) && (r_cnt == PER_END) && r_ch;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_ch       <= 1'b0;
      r_adc_cs   <= 1'b1;
      r_adc_clk  <= 1'b0;
      r_adc_mosi <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_bit      <= w_bit_nx;
      r_ch       <= w_ch_nx;
      r_adc_cs   <= w_cs_nx;
      r_adc_clk  <= w_sclk_nx;
      r_adc_mosi <= w_mosi_nx;
    end
  end

  // Channel 0 is parked in r_data0 so both outputs change together at publish time.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_shift   <= '0;
      r_data0   <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_capture)  r_shift <= {r_shift[10:0], r_miso_sync[1]};
      if (w_hold_ch0) r_data0 <= r_shift;
      if (w_publish) begin
        r_left  <= to_pcm(r_data0);
        r_right <= to_pcm(r_shift);
      end
      r_valid   <= w_publish;
      r_overrun <= w_tick && (r_state != S_IDLE);
    end
  end

  assign adc_cs       = r_adc_cs;
  assign adc_clk      = r_adc_clk;
  assign adc_mosi     = r_adc_mosi;
  assign sample_left  = r_left;
  assign sample_right = r_right;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

endmodule
